// File: rtl/bcd_range_counter.sv
// bcd_range_counter: N-digit BCD counter over [MIN_VAL..MAX_VAL] with wrap-around,
// up/down stepping, synchronous clear, validated parallel load, and same-cycle
// carry/borrow strobes for cascading time-keeping stages.
module bcd_range_counter #(
  parameter int NUM_DIGITS = 2,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = 59,
  parameter int RESET_VAL  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    en,
  input  logic                    up,
  input  logic                    down,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    carry_o,
  output logic                    borrow_o,
  output logic                    load_err
);

  localparam int W = 4 * NUM_DIGITS;

  // Decimal integer to packed BCD; evaluated at elaboration for the range constants.
  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           x;
    r = '0;
    x = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // True when every nibble is a legal decimal digit.
  function automatic logic digits_ok(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // +1 with the carry rippling through digits that roll 9 -> 0.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // -1 with the borrow rippling through digits that roll 0 -> 9.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [W-1:0] MIN_BCD   = to_bcd(MIN_VAL);
  localparam logic [W-1:0] MAX_BCD   = to_bcd(MAX_VAL);
  localparam logic [W-1:0] RESET_BCD = to_bcd(RESET_VAL);

  logic           step_up;
  logic           step_dn;
  logic           at_max;
  logic           at_min;
  logic           load_ok;
  logic [W-1:0]   count_nxt;
  logic           err_nxt;

  // Contradictory direction requests cancel; valid BCD orders like its decimal value,
  // so range checks can compare the packed words directly once the digits are legal.
  assign step_up = en & up & ~down;
  assign step_dn = en & down & ~up;
  assign at_max  = (count == MAX_BCD);
  assign at_min  = (count == MIN_BCD);
  assign load_ok = digits_ok(load_val) && (load_val >= MIN_BCD) && (load_val <= MAX_BCD);

  // Strobes fire in the wrap cycle itself so the next stage steps on the same edge;
  // clr/load pre-empt the step and reset holds them low.
  assign carry_o  = step_up & at_max & ~clr & ~load & ~rst;
  assign borrow_o = step_dn & at_min & ~clr & ~load & ~rst;

  // Next-state selection with priority clr > load > step > hold.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    count_nxt = count;
    err_nxt   = 1'b0;
    if (clr) begin
      count_nxt = RESET_BCD;
    end else if (load) begin
      if (load_ok) count_nxt = load_val;
      else         err_nxt   = 1'b1;
    end else if (step_up) begin
      count_nxt = at_max ? MIN_BCD : bcd_inc(count);
    end else if (step_dn) begin
      count_nxt = at_min ? MAX_BCD : bcd_dec(count);
    end
  end

  // Count and load-error registers; reset forces RESET_VAL immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      count    <= RESET_BCD;
      load_err <= 1'b0;
    end else begin
      count    <= count_nxt;
      load_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_range_counter.sv
// Testbench for bcd_range_counter: three instances (0..59, 1..31, 0..23) driven through
// scenario tasks; a decimal reference model pushes expectations to a scoreboard queue
// and each task pops and compares them once the DUT has produced its result.
module tb_bcd_range_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic       clr;
    logic       load;
    logic [7:0] lv;
    logic       en;
    logic       up;
    logic       down;
  } drv_t;

  typedef struct {
    int         k;
    logic [7:0] exp_cnt;
    logic [7:0] obs_cnt;
    logic       exp_lerr;
    logic       obs_lerr;
    logic       exp_c;
    logic       obs_c;
    logic       exp_b;
    logic       obs_b;
  } rec_t;

  drv_t       d   [3];
  logic [7:0] cnt [3];
  logic       cy  [3];
  logic       bw  [3];
  logic       le  [3];

  int mn [3] = '{0, 1, 0};
  int mx [3] = '{59, 31, 23};
  int rv [3] = '{0, 1, 0};
  int mval [3];

  rec_t sb [$];
  int   errors = 0;
  int   checks = 0;

  bcd_range_counter #(.NUM_DIGITS(2), .MIN_VAL(0), .MAX_VAL(59), .RESET_VAL(0)) u_sec (
    .clk(clk), .rst(rst), .clr(d[0].clr), .load(d[0].load), .load_val(d[0].lv),
    .en(d[0].en), .up(d[0].up), .down(d[0].down),
    .count(cnt[0]), .carry_o(cy[0]), .borrow_o(bw[0]), .load_err(le[0]));

  bcd_range_counter #(.NUM_DIGITS(2), .MIN_VAL(1), .MAX_VAL(31), .RESET_VAL(1)) u_day (
    .clk(clk), .rst(rst), .clr(d[1].clr), .load(d[1].load), .load_val(d[1].lv),
    .en(d[1].en), .up(d[1].up), .down(d[1].down),
    .count(cnt[1]), .carry_o(cy[1]), .borrow_o(bw[1]), .load_err(le[1]));

  bcd_range_counter #(.NUM_DIGITS(2), .MIN_VAL(0), .MAX_VAL(23), .RESET_VAL(0)) u_hour (
    .clk(clk), .rst(rst), .clr(d[2].clr), .load(d[2].load), .load_val(d[2].lv),
    .en(d[2].en), .up(d[2].up), .down(d[2].down),
    .count(cnt[2]), .carry_o(cy[2]), .borrow_o(bw[2]), .load_err(le[2]));

  function automatic logic [7:0] bcd8(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  // Drives one cycle on instance k, pushes the model's expectation, then records
  // the strobes just before the edge and the registered outputs just after it.
  task automatic apply(input int k, input logic c, input logic l, input logic [7:0] lv,
                       input logic e, input logic u, input logic dn);
    rec_t r;
    int   hi, lo, v;
    logic su, sd;
    @(negedge clk);
    d[k] = '{clr: c, load: l, lv: lv, en: e, up: u, down: dn};
    su = e & u & ~dn;
    sd = e & dn & ~u;
    r = '{default: '0};
    r.k     = k;
    r.exp_c = su && (mval[k] == mx[k]) && !c && !l;
    r.exp_b = sd && (mval[k] == mn[k]) && !c && !l;
    if (c) begin
      mval[k] = rv[k];
    end else if (l) begin
      hi = int'(lv[7:4]);
      lo = int'(lv[3:0]);
      v  = hi * 10 + lo;
      if (hi <= 9 && lo <= 9 && v >= mn[k] && v <= mx[k]) mval[k] = v;
      else r.exp_lerr = 1'b1;
    end else if (su) begin
      mval[k] = (mval[k] == mx[k]) ? mn[k] : mval[k] + 1;
    end else if (sd) begin
      mval[k] = (mval[k] == mn[k]) ? mx[k] : mval[k] - 1;
    end
    r.exp_cnt = bcd8(mval[k]);
    sb.push_back(r);
    #1;
    sb[sb.size()-1].obs_c = cy[k];
    sb[sb.size()-1].obs_b = bw[k];
    @(posedge clk);
    #1;
    sb[sb.size()-1].obs_cnt  = cnt[k];
    sb[sb.size()-1].obs_lerr = le[k];
    d[k] = '0;
  endtask

  task automatic test_reset();
    d[0] = '{clr: 1'b0, load: 1'b0, lv: 8'h00, en: 1'b1, up: 1'b1, down: 1'b0};
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cnt[k] !== bcd8(rv[k])) begin
        errors++; $display("FAIL reset_count dut%0d got %h want %h", k, cnt[k], bcd8(rv[k]));
      end
      checks++;
      if (le[k] !== 1'b0) begin
        errors++; $display("FAIL reset_load_err dut%0d got %b want 0", k, le[k]);
      end
      checks++;
      if (cy[k] !== 1'b0 || bw[k] !== 1'b0) begin
        errors++; $display("FAIL reset_strobes dut%0d got c=%b b=%b want 0", k, cy[k], bw[k]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    d[0] = '0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) mval[k] = rv[k];
  endtask

  task automatic test_count_up();
    rec_t r;
    for (int i = 0; i < 60; i++) apply(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      r = sb.pop_front();
      checks++; if (r.obs_cnt !== r.exp_cnt) begin errors++; $display("FAIL up_count dut%0d got %h want %h", r.k, r.obs_cnt, r.exp_cnt); end
      checks++; if (r.obs_c !== r.exp_c) begin errors++; $display("FAIL up_carry dut%0d got %b want %b at %h", r.k, r.obs_c, r.exp_c, r.exp_cnt); end
      checks++; if (r.obs_b !== r.exp_b) begin errors++; $display("FAIL up_borrow dut%0d got %b want %b", r.k, r.obs_b, r.exp_b); end
      checks++; if (r.obs_lerr !== r.exp_lerr) begin errors++; $display("FAIL up_load_err dut%0d got %b want %b", r.k, r.obs_lerr, r.exp_lerr); end
    end
  endtask

  task automatic test_count_down();
    rec_t r;
    apply(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    apply(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    while (sb.size() > 0) begin
      r = sb.pop_front();
      checks++; if (r.obs_cnt !== r.exp_cnt) begin errors++; $display("FAIL down_count dut%0d got %h want %h", r.k, r.obs_cnt, r.exp_cnt); end
      checks++; if (r.obs_b !== r.exp_b) begin errors++; $display("FAIL down_borrow dut%0d got %b want %b", r.k, r.obs_b, r.exp_b); end
      checks++; if (r.obs_c !== r.exp_c) begin errors++; $display("FAIL down_carry dut%0d got %b want %b", r.k, r.obs_c, r.exp_c); end
    end
  endtask

  task automatic test_day_range();
    rec_t r;
    apply(1, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    apply(1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    apply(1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    apply(1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    while (sb.size() > 0) begin
      r = sb.pop_front();
      checks++; if (r.obs_cnt !== r.exp_cnt) begin errors++; $display("FAIL day_count dut%0d got %h want %h", r.k, r.obs_cnt, r.exp_cnt); end
      checks++; if (r.obs_c !== r.exp_c) begin errors++; $display("FAIL day_carry dut%0d got %b want %b", r.k, r.obs_c, r.exp_c); end
      checks++; if (r.obs_b !== r.exp_b) begin errors++; $display("FAIL day_borrow dut%0d got %b want %b", r.k, r.obs_b, r.exp_b); end
      checks++; if (r.obs_lerr !== r.exp_lerr) begin errors++; $display("FAIL day_load_err dut%0d got %b want %b", r.k, r.obs_lerr, r.exp_lerr); end
    end
  endtask

  task automatic test_hour_ripple();
    rec_t r;
    apply(2, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    apply(2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    apply(2, 1'b0, 1'b1, 8'h19, 1'b0, 1'b0, 1'b0);
    apply(2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    apply(2, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    apply(2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    apply(2, 1'b0, 1'b1, 8'h23, 1'b0, 1'b0, 1'b0);
    apply(2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    apply(2, 1'b0, 1'b1, 8'h24, 1'b0, 1'b0, 1'b0);
    apply(2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      r = sb.pop_front();
      checks++; if (r.obs_cnt !== r.exp_cnt) begin errors++; $display("FAIL hour_count dut%0d got %h want %h", r.k, r.obs_cnt, r.exp_cnt); end
      checks++; if (r.obs_c !== r.exp_c) begin errors++; $display("FAIL hour_carry dut%0d got %b want %b", r.k, r.obs_c, r.exp_c); end
      checks++; if (r.obs_b !== r.exp_b) begin errors++; $display("FAIL hour_borrow dut%0d got %b want %b", r.k, r.obs_b, r.exp_b); end
      checks++; if (r.obs_lerr !== r.exp_lerr) begin errors++; $display("FAIL hour_load_err dut%0d got %b want %b", r.k, r.obs_lerr, r.exp_lerr); end
    end
  endtask

  task automatic test_load_reject();
    rec_t r;
    apply(0, 1'b0, 1'b1, 8'h3A, 1'b0, 1'b0, 1'b0);
    apply(0, 1'b1, 1'b1, 8'h3A, 1'b0, 1'b0, 1'b0);
    apply(0, 1'b0, 1'b1, 8'h45, 1'b1, 1'b1, 1'b0);
    apply(0, 1'b0, 1'b1, 8'h60, 1'b0, 1'b0, 1'b0);
    apply(0, 1'b0, 1'b1, 8'h59, 1'b0, 1'b0, 1'b0);
    apply(0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 1'b0);
    apply(0, 1'b1, 1'b1, 8'h20, 1'b1, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      r = sb.pop_front();
      checks++; if (r.obs_cnt !== r.exp_cnt) begin errors++; $display("FAIL load_count dut%0d got %h want %h", r.k, r.obs_cnt, r.exp_cnt); end
      checks++; if (r.obs_lerr !== r.exp_lerr) begin errors++; $display("FAIL load_err dut%0d got %b want %b", r.k, r.obs_lerr, r.exp_lerr); end
      checks++; if (r.obs_c !== r.exp_c) begin errors++; $display("FAIL load_carry dut%0d got %b want %b", r.k, r.obs_c, r.exp_c); end
    end
  endtask

  task automatic test_hold();
    rec_t r;
    apply(0, 1'b0, 1'b1, 8'h59, 1'b0, 1'b0, 1'b0);
    apply(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    apply(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    apply(0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    apply(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    apply(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    while (sb.size() > 0) begin
      r = sb.pop_front();
      checks++; if (r.obs_cnt !== r.exp_cnt) begin errors++; $display("FAIL hold_count dut%0d got %h want %h", r.k, r.obs_cnt, r.exp_cnt); end
      checks++; if (r.obs_c !== r.exp_c) begin errors++; $display("FAIL hold_carry dut%0d got %b want %b", r.k, r.obs_c, r.exp_c); end
      checks++; if (r.obs_b !== r.exp_b) begin errors++; $display("FAIL hold_borrow dut%0d got %b want %b", r.k, r.obs_b, r.exp_b); end
    end
  endtask

  task automatic test_async_reset();
    rec_t r;
    apply(0, 1'b0, 1'b1, 8'h37, 1'b0, 1'b0, 1'b0);
    r = sb.pop_front();
    checks++;
    if (r.obs_cnt !== r.exp_cnt) begin
      errors++; $display("FAIL arst_preload got %h want %h", r.obs_cnt, r.exp_cnt);
    end
    d[0] = '{clr: 1'b0, load: 1'b1, lv: 8'h12, en: 1'b0, up: 1'b0, down: 1'b0};
    #2 rst = 1'b1;
    #1;
    checks++;
    if (cnt[0] !== bcd8(rv[0])) begin
      errors++; $display("FAIL arst_count got %h want %h", cnt[0], bcd8(rv[0]));
    end
    @(posedge clk);
    #1;
    checks++;
    if (cnt[0] !== bcd8(rv[0]) || le[0] !== 1'b0) begin
      errors++; $display("FAIL arst_load_dropped got %h err=%b want %h err=0", cnt[0], le[0], bcd8(rv[0]));
    end
    @(negedge clk);
    d[0] = '0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) mval[k] = rv[k];
    apply(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    r = sb.pop_front();
    checks++;
    if (r.obs_cnt !== r.exp_cnt) begin
      errors++; $display("FAIL arst_resume got %h want %h", r.obs_cnt, r.exp_cnt);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      d[k]    = '0;
      mval[k] = rv[k];
    end
    test_reset();
    test_count_up();
    test_count_down();
    test_day_range();
    test_hour_ripple();
    test_load_reject();
    test_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
